mem_access_unit: RTL and testbench

- Memory-stage load/store unit. It consumes the execute stage's ALUResult as the effective address and its forwarded RD2 as store data.
- Drives a single-outstanding request/grant/response data bus and returns a sign- or zero-extended ReadData to writeback.
- Stalls the pipeline while a bus transaction is in flight.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_access_unit_load_extend.sv | 29 ++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the memory-stage load/store unit.
package mem_pkg;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = MEM_DATA_WIDTH / 8;
  localparam int TO_WIDTH       = 8;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Unsigned sizes only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half lane of a bus read word and sign/zero extends it.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [1:0]            i_a,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_a, 3'b000} +: 8];
  assign w_half = i_a[1] ? i_word[16 +: 16] : i_word[0 +: 16];

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_H:    o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_W:    o_data = i_word;
      F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_data = '0;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit with a single-outstanding req/gnt/rvalid bus.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
//
// state  | meaning
// IDLE   | waiting for a valid load/store from execute
// REQ    | BusReq high, bus fields held until BusGnt
// WAIT   | load granted, waiting for BusRvalid
// DONE   | one-cycle MemDone pulse, results valid
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ExValid,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [2:0]              Funct3,
  input  logic [DATA_WIDTH-1:0]   ALUResult,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  output logic                    BusReq,
  output logic                    BusWe,
  output logic [DATA_WIDTH-1:0]   BusAddr,
  output logic [DATA_WIDTH-1:0]   BusWdata,
  output logic [DATA_WIDTH/8-1:0] BusBe,
  input  logic                    BusGnt,
  input  logic                    BusRvalid,
  input  logic [DATA_WIDTH-1:0]   BusRdata,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    MemDone,
  output logic                    Stall,
  output logic                    BusError,
  output logic                    Misaligned
);
  state_e                  r_state;
  state_e                  w_next;
  logic [TO_WIDTH-1:0]     r_cnt;
  logic                    r_we;
  logic [2:0]              r_f3;
  logic [1:0]              r_a;
  logic [DATA_WIDTH-1:0]   r_bus_addr;
  logic [DATA_WIDTH-1:0]   r_bus_wdata;
  logic [DATA_WIDTH/8-1:0] r_bus_be;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic                    r_mis;

  logic                    w_accept;
  logic                    w_illegal;
  logic                    w_misalign;
  logic                    w_timeout;
  logic                    w_capture;
  logic                    w_abort;
  logic [DATA_WIDTH/8-1:0] w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH-1:0]   w_ext;

  assign w_accept  = (r_state == S_IDLE) && ExValid && (MemRead || MemWrite);
  assign w_illegal = !f3_legal(Funct3, MemWrite);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = !w_illegal &&
                      (((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                       ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Half lanes use only addr[1] and words no low bits, so untrapped accesses self-align.
  always_comb begin
    w_be    = '1;
    w_wdata = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {ALUResult[1], 1'b0};
        w_wdata = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .i_word   (BusRdata),
    .i_a      (r_a),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

  assign w_timeout = (r_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign w_capture = !r_we && BusRvalid &&
                     (((r_state == S_REQ) && BusGnt) || (r_state == S_WAIT));
  assign w_abort   = w_timeout &&
                     (((r_state == S_REQ) && !BusGnt) || ((r_state == S_WAIT) && !BusRvalid));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_illegal || w_misalign) ? S_DONE : S_REQ;
      S_REQ: begin
        if (BusGnt)         w_next = (r_we || BusRvalid) ? S_DONE : S_WAIT;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WAIT: if (BusRvalid || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_f3        <= '0;
      r_a         <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mis       <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_REQ) || (r_state == S_WAIT)) r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_cnt       <= '0;
        r_we        <= MemWrite;
        r_f3        <= Funct3;
        r_a         <= ALUResult[1:0];
        r_bus_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
        r_bus_wdata <= w_wdata;
        r_bus_be    <= w_be;
        r_rdata     <= '0;
        r_err       <= w_illegal;
        r_mis       <= w_misalign;
      end
      if (w_capture) r_rdata <= w_ext;
      if (w_abort) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  assign BusReq     = (r_state == S_REQ);
  assign BusWe      = BusReq && r_we;
  assign BusAddr    = r_bus_addr;
  assign BusWdata   = r_bus_wdata;
  assign BusBe      = r_bus_be;
  assign ReadData   = r_rdata;
  assign MemDone    = (r_state == S_DONE);
  assign BusError   = r_err;
  assign Misaligned = r_mis;
  // Accept-cycle stall is combinational, so it is also masked by reset directly.
  assign Stall      = !rst && (w_accept || (r_state == S_REQ) || (r_state == S_WAIT));
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized ops vs a lane model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ExValid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] ALUResult = 32'h0, WriteData = 32'h0;
  logic        BusReq, BusWe;
  logic [31:0] BusAddr, BusWdata;
  logic [3:0]  BusBe;
  logic        BusGnt = 1'b0, BusRvalid = 1'b0;
  logic [31:0] BusRdata = 32'h0;
  logic [31:0] ReadData;
  logic        MemDone, Stall, BusError, Misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .ExValid(ExValid), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWdata(BusWdata), .BusBe(BusBe),
    .BusGnt(BusGnt), .BusRvalid(BusRvalid), .BusRdata(BusRdata),
    .ReadData(ReadData), .MemDone(MemDone), .Stall(Stall),
    .BusError(BusError), .Misaligned(Misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // gnt_dly: REQ cycles before the grant cycle; rv_dly: cycles from grant to rvalid (0 = same cycle).
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
    int          n, off, stall_cnt, req_cnt, exp_req, exp_stall;
    logic        illegal, mis, done, first_req, timed_out;
    logic [31:0] exp_be, exp_wd, exp_rd;
    longint      v, mask;
    n       = nbytes(f3);
    illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    off     = int'(addr[1:0]);
    mis     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = !illegal && ((off % n) != 0);
`endif
    if (!illegal) off = off - (off % n);
    exp_be = ((32'd1 << n) - 32'd1) << off;
    exp_wd = 32'h0;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % n) +: 8];
    mask = (longint'(1) << (8*n)) - 1;
    v    = (longint'(rdata) >> (8*off)) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
    exp_rd    = v[31:0];
    timed_out = !illegal && !mis && (gnt_dly >= 255);
    if (timed_out || mis) exp_rd = 32'h0;
    exp_req   = (illegal || mis) ? 0 : (timed_out ? 255 : gnt_dly + 1);
    exp_stall = 1 + exp_req + ((illegal || mis || timed_out || we) ? 0 : rv_dly);

    @(posedge clk); #1;
    ExValid   = 1'b1;
    MemWrite  = we;
    MemRead   = we ? 1'($urandom_range(0, 1)) : 1'b1;
    Funct3    = f3;
    ALUResult = addr;
    WriteData = wdata;
    @(negedge clk);
    check($sformatf("%s.accept_stall", tag), 32'(Stall), 32'd1);
    check($sformatf("%s.accept_nodone", tag), 32'(MemDone), 32'd0);
    stall_cnt = Stall ? 1 : 0;
    @(posedge clk); #1;
    ExValid   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = $urandom;
    WriteData = $urandom;
    Funct3    = 3'($urandom);
    done      = 1'b0;
    first_req = 1'b1;
    req_cnt   = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      BusGnt = (cyc == gnt_dly);
      if (we || cyc < gnt_dly) BusRvalid = 1'($urandom_range(0, 1));
      else                     BusRvalid = (cyc == gnt_dly + rv_dly);
      BusRdata = (!we && cyc == gnt_dly + rv_dly) ? rdata : $urandom;
      @(negedge clk);
      if (MemDone) begin
        done = 1'b1;
        check($sformatf("%s.done_stall", tag), 32'(Stall), 32'd0);
        check($sformatf("%s.done_busreq", tag), 32'(BusReq), 32'd0);
        check($sformatf("%s.buserror", tag), 32'(BusError), 32'(illegal || timed_out));
        check($sformatf("%s.misaligned", tag), 32'(Misaligned), 32'(mis));
        if (!we && !illegal) check($sformatf("%s.readdata", tag), ReadData, exp_rd);
      end else begin
        if (Stall) stall_cnt++;
        if (BusReq) begin
          req_cnt++;
          if (first_req) begin
            first_req = 1'b0;
            check($sformatf("%s.busaddr", tag), BusAddr, addr & 32'hFFFF_FFFC);
            check($sformatf("%s.busbe", tag), 32'(BusBe), exp_be);
            check($sformatf("%s.buswe", tag), 32'(BusWe), 32'(we));
            if (we) check($sformatf("%s.buswdata", tag), BusWdata, exp_wd);
          end
        end
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    BusGnt    = 1'b0;
    BusRvalid = 1'b0;
    check($sformatf("%s.done_seen", tag), 32'(done), 32'd1);
    check($sformatf("%s.req_cycles", tag), 32'(req_cnt), 32'(exp_req));
    check($sformatf("%s.stall_cycles", tag), 32'(stall_cnt), 32'(exp_stall));
  endtask

  initial begin
    #12;
    check("rst.busreq", 32'(BusReq), 32'd0);
    check("rst.stall", 32'(Stall), 32'd0);
    check("rst.memdone", 32'(MemDone), 32'd0);
    check("rst.readdata", ReadData, 32'd0);
    check("rst.buserror", 32'(BusError), 32'd0);
    check("rst.misaligned", 32'(Misaligned), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op("sw",      1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         1, 0);
    run_op("lb",      1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_0000, 0, 3);
    run_op("lbu",     1'b0, 3'b100, 32'h0000_1003, 32'h0,         32'h80FF_0000, 0, 3);
    run_op("sh",      1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,         0, 0);
    run_op("lhu",     1'b0, 3'b101, 32'h0000_2002, 32'h0,         32'hABCD_1234, 1, 0);
    run_op("lh",      1'b0, 3'b001, 32'h0000_2000, 32'h0,         32'h1234_8001, 2, 1);
    run_op("sb",      1'b1, 3'b000, 32'h0000_3001, 32'h0000_005A, 32'h0,         0, 0);
    run_op("lw_mis",  1'b0, 3'b010, 32'h0000_1002, 32'h0,         32'h1234_5678, 0, 1);
    run_op("sh_mis",  1'b1, 3'b001, 32'h0000_1003, 32'h0000_C0DE, 32'h0,         0, 0);
    run_op("ill_011", 1'b0, 3'b011, 32'h0000_1000, 32'h0,         32'h0,         0, 0);
    run_op("ill_sbu", 1'b1, 3'b100, 32'h0000_1000, 32'h0000_0011, 32'h0,         0, 0);
    run_op("timeout", 1'b0, 3'b010, 32'h0000_4000, 32'h0,         32'h0,         1000, 0);

    // ExValid without a memory op is ignored.
    @(posedge clk); #1;
    ExValid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = 32'h5000;
    @(negedge clk);
    check("nop.stall", 32'(Stall), 32'd0);
    @(posedge clk); #1;
    ExValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("nop.memdone", 32'(MemDone), 32'd0);
      check("nop.busreq", 32'(BusReq), 32'd0);
    end

    for (int k = 0; k < 40; k++) begin
      run_op($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while BusReq is high drops it asynchronously.
    @(posedge clk); #1;
    ExValid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h6000;
    @(posedge clk); #1;
    ExValid = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    check("rstreq.busreq_before", 32'(BusReq), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstreq.busreq", 32'(BusReq), 32'd0);
    check("rstreq.stall", 32'(Stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while awaiting BusRvalid; the late response must be ignored.
    @(posedge clk); #1;
    ExValid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h7000;
    @(posedge clk); #1;
    ExValid = 1'b0; MemRead = 1'b0; BusGnt = 1'b1;
    @(posedge clk); #1;
    BusGnt = 1'b0;
    @(negedge clk);
    check("rstwait.stall_before", 32'(Stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstwait.stall", 32'(Stall), 32'd0);
    check("rstwait.busreq", 32'(BusReq), 32'd0);
    check("rstwait.memdone", 32'(MemDone), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    BusRvalid = 1'b1; BusRdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_rv.memdone", 32'(MemDone), 32'd0);
      check("late_rv.readdata", ReadData, 32'd0);
      check("late_rv.stall", 32'(Stall), 32'd0);
    end
    BusRvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
